// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: opcodes, funct3 values, request kinds and ALU-control codes.
// Also used by the control decoders elsewhere in the codebase.
package rv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_I    = 3'd1,
    KIND_LW   = 3'd2,
    KIND_SW   = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_JAL  = 3'd5,
    KIND_BAD6 = 3'd6,
    KIND_BAD7 = 3'd7
  } kind_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  // True when v is representable as a signed value whose sign bit is v[msb].
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> msb);
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

  // Returns {legal, funct3} for an ALU-control code.
  function automatic logic [3:0] alu_decode(input logic [2:0] alu);
    logic [3:0] res;
    case (alu)
      ALU_ADD: res = {1'b1, F3_ADD_SUB};
      ALU_SUB: res = {1'b1, F3_ADD_SUB};
      ALU_AND: res = {1'b1, F3_AND};
      ALU_OR:  res = {1'b1, F3_OR};
      ALU_SLT: res = {1'b1, F3_SLT};
      default: res = {1'b0, 3'b000};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational immediate range check and RV32I bit-scatter for each request kind.
// fields holds the immediate bits in their final instruction positions, zero elsewhere.
module imm_packer
  import rv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [31:0] imm,
  output logic        legal,
  output logic [31:0] fields
);

  // Per-kind legality and scatter of the immediate.
  always_comb begin
    legal  = 1'b0;
    fields = 32'h0000_0000;
    case (kind_e'(kind))
      KIND_R: begin
        legal  = 1'b1;
        fields = 32'h0000_0000;
      end
      KIND_I, KIND_LW: begin
        legal  = sext_fits(imm, 11);
        fields = {imm[11:0], 20'd0};
      end
      KIND_SW: begin
        legal  = sext_fits(imm, 11);
        fields = {imm[11:5], 13'd0, imm[4:0], 7'd0};
      end
      KIND_BEQ: begin
        legal  = sext_fits(imm, 12) && (imm[0] == 1'b0);
        fields = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
      end
      KIND_JAL: begin
        legal  = sext_fits(imm, 20) && (imm[0] == 1'b0);
        fields = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
      end
      default: begin
        legal  = 1'b0;
        fields = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Request-to-RV32I instruction encoder with a two-entry output skid buffer and
// an instruction-address counter; illegal requests are consumed and flagged in err.
module instr_encoder
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [2:0]  in_alu,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  logic        imm_legal_s;
  logic [31:0] imm_fields_s;
  logic        kind_ok_s;
  logic [31:0] base_s;
  logic [31:0] word_s;
  logic [3:0]  alu_dec_s;
  logic        req_legal_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  cnt_s;
  logic [1:0]  nxt_cnt_s;

  logic        in_ready_r;
  logic        err_r;
  logic [31:0] addr_r;
  logic        head_valid_r;
  logic        skid_valid_r;
  entry_t      head_r;
  entry_t      skid_r;
  entry_t      new_s;

  imm_packer u_imm_packer (
    .kind   (in_kind),
    .imm    (in_imm),
    .legal  (imm_legal_s),
    .fields (imm_fields_s)
  );

  // Opcode/register/funct fields per kind, merged with the scattered immediate.
  always_comb begin
    alu_dec_s = alu_decode(in_alu);
    kind_ok_s = 1'b0;
    base_s    = 32'h0000_0000;
    case (kind_e'(in_kind))
      KIND_R: begin
        kind_ok_s = alu_dec_s[3];
        base_s    = {(in_alu == ALU_SUB) ? F7_SUB : F7_BASE, in_rs2, in_rs1,
                     alu_dec_s[2:0], in_rd, OP_R};
      end
      KIND_I: begin
        kind_ok_s = alu_dec_s[3] && (in_alu != ALU_SUB);
        base_s    = {12'd0, in_rs1, alu_dec_s[2:0], in_rd, OP_I};
      end
      KIND_LW: begin
        kind_ok_s = 1'b1;
        base_s    = {12'd0, in_rs1, F3_LW, in_rd, OP_LW};
      end
      KIND_SW: begin
        kind_ok_s = 1'b1;
        base_s    = {7'd0, in_rs2, in_rs1, F3_SW, 5'd0, OP_SW};
      end
      KIND_BEQ: begin
        kind_ok_s = 1'b1;
        base_s    = {7'd0, in_rs2, in_rs1, F3_BEQ, 5'd0, OP_BEQ};
      end
      KIND_JAL: begin
        kind_ok_s = 1'b1;
        base_s    = {20'd0, in_rd, OP_JAL};
      end
      default: begin
        kind_ok_s = 1'b0;
        base_s    = 32'h0000_0000;
      end
    endcase
    word_s      = base_s | imm_fields_s;
    req_legal_s = kind_ok_s && imm_legal_s;
  end

  // Handshake qualifiers and the occupancy the buffer will have after this edge.
  // in_ready itself comes from a register; clr only masks it for its own cycle.
  always_comb begin
    in_ready  = in_ready_r && !clr;
    accept_s  = in_valid && in_ready;
    push_s    = accept_s && req_legal_s;
    pop_s     = head_valid_r && out_ready;
    new_s     = '{instr: word_s, addr: addr_r};
    cnt_s     = {1'b0, head_valid_r} + {1'b0, skid_valid_r};
    nxt_cnt_s = cnt_s + {1'b0, push_s} - {1'b0, pop_s};
  end

  // Control state: ready flag, sticky error and the address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b0;
      err_r      <= 1'b0;
      addr_r     <= 32'h0000_0000;
    end else if (clr) begin
      in_ready_r <= 1'b1;
      err_r      <= 1'b0;
      addr_r     <= 32'h0000_0000;
    end else begin
      in_ready_r <= (nxt_cnt_s < 2'd2);
      if (accept_s && !req_legal_s) begin
        err_r <= 1'b1;
      end
      if (push_s) begin
        addr_r <= addr_r + 32'd4;
      end
    end
  end

  // Two-entry skid buffer: head drives the outputs, skid holds the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      head_r       <= '0;
      skid_r       <= '0;
    end else if (clr) begin
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      head_r       <= '0;
      skid_r       <= '0;
    end else if (pop_s) begin
      if (skid_valid_r) begin
        head_r       <= skid_r;
        skid_valid_r <= push_s;
        if (push_s) begin
          skid_r <= new_s;
        end
      end else begin
        head_valid_r <= push_s;
        if (push_s) begin
          head_r <= new_s;
        end
      end
    end else if (push_s) begin
      if (head_valid_r) begin
        skid_valid_r <= 1'b1;
        skid_r       <= new_s;
      end else begin
        head_valid_r <= 1'b1;
        head_r       <= new_s;
      end
    end
  end

  assign out_valid = head_valid_r;
  assign out_instr = head_r.instr;
  assign out_addr  = head_r.addr;
  assign err       = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, backpressure,
// illegal requests, mid-stream reset and clr.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_alu;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bp_i [3];
  logic [31:0] bp_a [3];
  int          idx;
  logic        take;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_alu    (in_alu),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] k, input logic [2:0] a, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    in_kind = k; in_alu = a; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input string tag, input logic [2:0] k, input logic [2:0] a,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im);
    @(negedge clk);
    drive(k, a, d, s1, s2, im);
    for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] ei, input logic [31:0] ea);
    @(negedge clk);
    for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, ei);
    chk({tag, "_addr"}, out_addr, ea);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_kind = 3'd0; in_alu = 3'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    bp_i[0] = 32'h002081B3; bp_i[1] = 32'h407302B3; bp_i[2] = 32'h00812203;
    bp_a[0] = 32'd0;        bp_a[1] = 32'd4;        bp_a[2] = 32'd8;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr",  out_addr,  32'd0);
    chk("rst_err",       32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Encodings
    send("add", 3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    expect_word("add", 32'h002081B3, 32'd0);
    send("sub", 3'd0, 3'b001, 5'd5, 5'd6, 5'd7, 32'd0);
    expect_word("sub", 32'h407302B3, 32'd4);
    send("lw", 3'd2, 3'b000, 5'd4, 5'd2, 5'd0, 32'd8);
    expect_word("lw", 32'h00812203, 32'd8);
    send("sw", 3'd3, 3'b000, 5'd0, 5'd2, 5'd5, -32'sd4);
    expect_word("sw", 32'hFE512E23, 32'd12);
    send("beq", 3'd4, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8);
    expect_word("beq", 32'hFE208CE3, 32'd16);
    send("jal", 3'd5, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048);
    expect_word("jal", 32'h001000EF, 32'd20);
    send("addi", 3'd1, 3'b000, 5'd1, 5'd0, 5'd0, -32'sd1);
    expect_word("addi", 32'hFFF00093, 32'd24);

    // Restart addresses, then backpressure with three back-to-back requests
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    send("bp1", 3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
    send("bp2", 3'd0, 3'b001, 5'd5, 5'd6, 5'd7, 32'd0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    drive(3'd2, 3'b000, 5'd4, 5'd2, 5'd0, 32'd8);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_instr", out_instr, 32'h002081B3);
      chk("bp_hold_addr", out_addr, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      if (out_valid) begin
        chk("bp_order_instr", out_instr, bp_i[idx]);
        chk("bp_order_addr", out_addr, bp_a[idx]);
        idx++;
      end
      @(posedge clk); #1;
      if (take) in_valid = 1'b0;
    end
    chk("bp_word_count", 32'(idx), 32'd3);
    out_ready = 1'b0; in_valid = 1'b0;

    // Illegal requests
    send("ill_i4096", 3'd1, 3'b000, 5'd1, 5'd1, 5'd0, 32'd4096);
    chk("ill_i4096_err", 32'(err), 32'd1);
    chk("ill_i4096_no_out", 32'(out_valid), 32'd0);
    send("ill_beq3", 3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3);
    chk("ill_beq3_err", 32'(err), 32'd1);
    chk("ill_beq3_no_out", 32'(out_valid), 32'd0);
    send("post_ill", 3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("post_ill", 32'h002081B3, 32'd12);

    // Mid-stream reset with two buffered words
    send("pre_rst1", 3'd0, 3'b001, 5'd5, 5'd6, 5'd7, 32'd0);
    send("pre_rst2", 3'd2, 3'b000, 5'd4, 5'd2, 5'd0, 32'd8);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    chk("midrst_no_word", 32'(out_valid), 32'd0);
    send("after_rst", 3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("after_rst", 32'h002081B3, 32'd0);
    send("w4", 3'd0, 3'b001, 5'd5, 5'd6, 5'd7, 32'd0);
    expect_word("w4", 32'h407302B3, 32'd4);
    send("w8", 3'd2, 3'b000, 5'd4, 5'd2, 5'd0, 32'd8);
    expect_word("w8", 32'h00812203, 32'd8);
    send("ill_kind7", 3'd7, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("ill_kind7_err", 32'(err), 32'd1);

    // clr with err set and counter at 12; in_valid during clr is ignored
    @(negedge clk);
    drive(3'd0, 3'b000, 5'd3, 5'd1, 5'd2, 32'd0);
    clr = 1'b1;
    #1;
    chk("clr_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_err_cleared", 32'(err), 32'd0);
    chk("clr_no_word", 32'(out_valid), 32'd0);
    send("after_clr", 3'd3, 3'b000, 5'd0, 5'd2, 5'd5, -32'sd4);
    expect_word("after_clr", 32'hFE512E23, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have clr, input, 1, synchronous flush plus address restart.
REQ-004 SHALL have in_valid, input, 1, request present.
REQ-005 SHALL have in_ready, output, 1, request accepted when in_valid && in_ready.
REQ-006 SHALL have in_kind, input, 3, 0 R-ALU, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6-7 illegal.
REQ-007 SHALL have in_alu, input, 3, ALU control code: 000 add, 001 sub, 010 and, 011 or, 101 slt, others illegal; ignored for kinds 2-5.
REQ-008 SHALL have in_rd, in_rs1, in_rs2, input, 5 each, register fields; unused fields ignored.
REQ-009 SHALL have in_imm, input, 32, signed byte-granular immediate.
REQ-010 SHALL have out_valid, output, 1, encoded word present.
REQ-011 SHALL have out_ready, input, 1, word consumed when out_valid && out_ready.
REQ-012 SHALL have out_instr, output, 32, RV32I instruction word.
REQ-013 SHALL have out_addr, output, 32, instruction-memory byte address of out_instr.
REQ-014 SHALL have err, output, 1, sticky illegal-request flag.

Function
REQ-015 SHALL encode ALU ops as funct3 000 add/sub, 111 and, 110 or, 010 slt, with funct7 bit 5 = 1 only for R-type sub.
REQ-016 SHALL use opcodes 0110011 R, 0010011 I, 0000011 LW (funct3 010), 0100011 SW (funct3 010), 1100011 BEQ (funct3 000), 1101111 JAL.
REQ-017 SHALL place immediates in standard I, S, B and J bit-scatter formats.
REQ-018 SHALL use these legal ranges: I/S -2048..2047; B -4096..4094 even; J -1048576..1048574 even.
REQ-019 SHALL treat as illegal: an out-of-range or odd immediate, an illegal in_kind, an illegal in_alu, or sub with I-ALU.
REQ-020 SHALL consume an illegal request, set err, emit no word and leave the address unchanged.
REQ-021 SHALL present the word of a request accepted in cycle N at the outputs in cycle N+1 at the earliest, never combinationally.
REQ-022 SHALL buffer two words (skid); in_ready = entry count < 2, from registered state only.
REQ-023 SHALL sustain 1 word/cycle while out_ready is held high.
REQ-024 SHALL deliver words in acceptance order; out_instr and out_addr stay stable while out_valid && !out_ready.
REQ-025 SHALL assign out_addr from a counter that starts at 0, advances by 4 per emitted legal word, and wraps 0xFFFFFFFC -> 0.
REQ-026 SHALL on clr empty the buffer, zero the counter, clear err, deassert in_ready for that cycle and ignore any in_valid.
REQ-027 SHALL on simultaneous accept and consume with count 2 keep count 2 and preserve ordering.

Reset
REQ-028 SHALL on rst_n low immediately force: out_valid 0, in_ready 0, out_instr 0, out_addr 0, err 0, buffer empty.
REQ-029 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-030 SHALL discard in-flight buffered words on a reset mid-stream; no partial word is emitted.

Structure
REQ-031 SHALL keep opcode constants, funct3 constants, in_kind codes and ALU-control codes in a shared package (rv_pkg), also used by the existing control decoders.
REQ-032 SHALL contain one sub-module, imm_packer: a combinational kind/imm to {legal, scattered fields} function.

Verification
REQ-033 SHALL check R add rd3 rs1 1 rs2 2 -> 0x002081B3 at addr 0; then R sub rd5 rs1 6 rs2 7 -> 0x407302B3 at addr 4.
REQ-034 SHALL check LW rd4 rs1 2 imm 8 -> 0x00812203; SW rs2 5 rs1 2 imm -4 -> 0xFE512E23; BEQ rs1 1 rs2 2 imm -8 -> 0xFE208CE3.
REQ-035 SHALL check that with out_ready held 0 and 3 back-to-back requests, in_ready falls after 2, and that on release all words emerge in order with addrs 0,4,8.
REQ-036 SHALL check I-ALU imm 4096 and BEQ imm 3 -> err=1, no output, and a next legal word at an unchanged addr.
REQ-037 SHALL check that rst_n pulsed low with 2 buffered words gives out_valid 0 immediately, and that the next word after reset has addr 0.
REQ-038 SHALL check that clr asserted with err=1 and addr 12 clears err, and that the next word has addr 0.
